// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor-unit blocks.
//  state_t           FSM encoding used by the window averagers
//  DEFAULT_INIT_VAL  value preloaded into every window slot after reset
//  road_w()          width of a road index for a given road count (at least 1 bit)
package sensor_pkg;

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_READ,
      S_WRITE
   } state_t;

   localparam int unsigned DEFAULT_INIT_VAL = 20;

   function automatic int unsigned road_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sensor_window_ram.sv
// Shared circular sample store: 1 read port, 1 write port, synchronous read
// with one cycle of latency. No reset; the owner initialises the contents.
//  clk    rising-edge clock
//  we     write enable
//  waddr  write address {road, ptr}
//  wdata  write data
//  raddr  read address {road, ptr}
//  rdata  registered read data, valid the cycle after raddr
module sensor_window_ram #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DW    = 8,
   parameter int unsigned WORDS = 256
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [WORDS];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port, one cycle latency
   always_ff @(posedge clk) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/road_sensor_avg_array.sv
// Multi-road sliding-window vehicle-count averager. One shared sample store
// holds a window of 2**DEPTH_LOG2 samples per road; a running sum per road
// turns each update into one add and one subtract.
// Optional feature macro: SENSOR_CONGEST_EN (adds the congest output).
//  clk          rising-edge clock
//  reset        synchronous, active-high reset
//  sample_valid new sample offered
//  sample_ready block can accept a sample this cycle
//  sample_road  target road of the sample
//  sample_data  vehicle count for that road
//  avg_valid    one-cycle pulse, avg_road/avg_out just updated
//  avg_road     road whose average just changed
//  avg_out      new average of avg_road
//  avg_all      all averages, road r at [r*DW +: DW]
//  congest      per-road avg >= CONGEST_THR (SENSOR_CONGEST_EN only)
module road_sensor_avg_array
   import sensor_pkg::*;
#(
   parameter int unsigned NUM_ROADS   = 4,
   parameter int unsigned DEPTH_LOG2  = 6,
   parameter int unsigned DW          = 8,
   parameter int unsigned INIT_VAL    = DEFAULT_INIT_VAL,
   parameter int unsigned CONGEST_THR = 200
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            sample_valid,
   output logic                            sample_ready,
   input  logic [road_w(NUM_ROADS)-1:0]    sample_road,
   input  logic [DW-1:0]                   sample_data,
   output logic                            avg_valid,
   output logic [road_w(NUM_ROADS)-1:0]    avg_road,
   output logic [DW-1:0]                   avg_out,
   output logic [NUM_ROADS*DW-1:0]         avg_all
`ifdef SENSOR_CONGEST_EN
   ,
   output logic [NUM_ROADS-1:0]            congest
`endif
);

   localparam int unsigned RW        = road_w(NUM_ROADS);
   localparam int unsigned AW        = RW + DEPTH_LOG2;
   localparam int unsigned SW        = DW + DEPTH_LOG2;
   localparam int unsigned WORDS     = NUM_ROADS << DEPTH_LOG2;
   localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);
   localparam logic [DW-1:0] INIT_D    = DW'(INIT_VAL);
   localparam logic [SW-1:0] INIT_SUM  = SW'(INIT_VAL) << DEPTH_LOG2;

   state_t                state;
   logic [AW-1:0]         init_addr;
   logic [RW-1:0]         road_q;
   logic [DW-1:0]         data_q;
   logic [DEPTH_LOG2-1:0] ptr [NUM_ROADS];
   logic [SW-1:0]         sum [NUM_ROADS];
   logic [DW-1:0]         rd_data;

   logic                  we_c;
   logic [AW-1:0]         waddr_c;
   logic [AW-1:0]         raddr_c;
   logic [DW-1:0]         wdata_c;
   logic [SW-1:0]         new_sum_c;
   logic [DW-1:0]         new_avg_c;

   sensor_window_ram #(
      .AW    (AW),
      .DW    (DW),
      .WORDS (WORDS)
   ) u_ram (
      .clk   (clk),
      .we    (we_c),
      .waddr (waddr_c),
      .wdata (wdata_c),
      .raddr (raddr_c),
      .rdata (rd_data)
   );

   // Store port steering and running-sum update. The add may wrap
   // transiently; the subtract brings it back into range before the shift.
   always_comb begin
      raddr_c   = {road_q, ptr[road_q]};
      waddr_c   = raddr_c;
      wdata_c   = data_q;
      we_c      = 1'b0;
      new_sum_c = sum[road_q] + SW'(data_q) - SW'(rd_data);
      new_avg_c = new_sum_c[SW-1 -: DW];
      case (state)
         S_INIT: begin
            we_c    = 1'b1;
            waddr_c = init_addr;
            wdata_c = INIT_D;
         end
         S_WRITE: we_c = 1'b1;
         default: ;
      endcase
   end

   // Control FSM with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_INIT;
         init_addr    <= '0;
         sample_ready <= 1'b0;
         avg_valid    <= 1'b0;
         avg_road     <= '0;
         avg_out      <= INIT_D;
         avg_all      <= {NUM_ROADS{INIT_D}};
         road_q       <= '0;
         data_q       <= '0;
         for (int r = 0; r < NUM_ROADS; r++) begin
            ptr[r] <= '0;
            sum[r] <= INIT_SUM;
         end
      end else begin
         avg_valid <= 1'b0;
         case (state)
            S_INIT: begin
               init_addr <= init_addr + AW'(1);
               if (init_addr == LAST_ADDR) begin
                  state        <= S_IDLE;
                  sample_ready <= 1'b1;
               end
            end
            S_IDLE: begin
               // Out-of-range roads are consumed here and never reach the store
               if (sample_valid && sample_ready && (32'(sample_road) < NUM_ROADS)) begin
                  road_q       <= sample_road;
                  data_q       <= sample_data;
                  sample_ready <= 1'b0;
                  state        <= S_READ;
               end
            end
            S_READ: state <= S_WRITE;
            S_WRITE: begin
               ptr[road_q]               <= ptr[road_q] + DEPTH_LOG2'(1);
               sum[road_q]               <= new_sum_c;
               avg_all[road_q*DW +: DW]  <= new_avg_c;
               avg_out                   <= new_avg_c;
               avg_road                  <= road_q;
               avg_valid                 <= 1'b1;
               sample_ready              <= 1'b1;
               state                     <= S_IDLE;
            end
            default: state <= S_INIT;
         endcase
      end
   end

`ifdef SENSOR_CONGEST_EN
   // Congestion flags, updated together with avg_all
   always_ff @(posedge clk) begin
      if (reset) begin
         congest <= '0;
      end else if (state == S_WRITE) begin
         congest[road_q] <= (32'(new_avg_c) >= CONGEST_THR);
      end
   end
`else
   logic unused_congest_thr;
   assign unused_congest_thr = (CONGEST_THR != 0);
`endif

endmodule

// File: tb/tb_road_sensor_avg_array.sv
// Self-checking bench for road_sensor_avg_array: reset/INIT timing, a table of
// single-sample updates, a full-window wrap, reset during an update, an
// out-of-range road on a 3-road instance and, with SENSOR_CONGEST_EN, the
// congestion flag edges.
module tb_road_sensor_avg_array;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic [1:0]  sample_road = '0;
   logic [7:0]  sample_data = '0;
   logic        avg_valid;
   logic [1:0]  avg_road;
   logic [7:0]  avg_out;
   logic [31:0] avg_all;

   logic        reset3 = 1'b1;
   logic        valid3 = 1'b0;
   logic        ready3;
   logic [1:0]  road3 = '0;
   logic [7:0]  data3 = '0;
   logic        avg_valid3;
   logic [1:0]  avg_road3;
   logic [7:0]  avg_out3;
   logic [23:0] avg_all3;
`ifdef SENSOR_CONGEST_EN
   logic [3:0]  congest;
   logic [2:0]  congest3;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   road_sensor_avg_array u_dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_road  (sample_road),
      .sample_data  (sample_data),
      .avg_valid    (avg_valid),
      .avg_road     (avg_road),
      .avg_out      (avg_out),
      .avg_all      (avg_all)
`ifdef SENSOR_CONGEST_EN
      ,
      .congest      (congest)
`endif
   );

   road_sensor_avg_array #(.NUM_ROADS(3)) u_dut3 (
      .clk          (clk),
      .reset        (reset3),
      .sample_valid (valid3),
      .sample_ready (ready3),
      .sample_road  (road3),
      .sample_data  (data3),
      .avg_valid    (avg_valid3),
      .avg_road     (avg_road3),
      .avg_out      (avg_out3),
      .avg_all      (avg_all3)
`ifdef SENSOR_CONGEST_EN
      ,
      .congest      (congest3)
`endif
   );

   typedef struct {
      int          road;
      int          data;
      int          exp_avg;
      logic [31:0] exp_all;
   } vec_t;

   vec_t vt [7];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle reset pulse on the 4-road instance
   task automatic do_reset();
      reset        = 1'b1;
      sample_valid = 1'b0;
      step();
      reset = 1'b0;
   endtask

   // Cycles until sample_ready rises, counting any avg_valid seen meanwhile
   task automatic wait_ready(output int n, output int pulses);
      n = 0;
      pulses = 0;
      while (!sample_ready && n < 2000) begin
         step();
         n++;
         if (avg_valid) pulses++;
      end
   endtask

   // Offer one sample; lat = cycles from driving valid until avg_valid is seen, -1 if never
   task automatic send(input int road, input int data, output int lat);
      int n;
      n = 0;
      while (!sample_ready && n < 2000) begin
         step();
         n++;
      end
      if (!sample_ready) chk("ready_wait_timeout", 0, 1);
      sample_valid = 1'b1;
      sample_road  = 2'(road);
      sample_data  = 8'(data);
      step();
      sample_valid = 1'b0;
      lat = 1;
      while (!avg_valid && lat < 8) begin
         step();
         lat++;
      end
      if (!avg_valid) lat = -1;
   endtask

   initial begin
      int n, pulses, lat, rise, fall;

      // road, data, expected avg of that road, expected avg_all {r3,r2,r1,r0}
      vt[0] = '{3,  84, 21, 32'h15141414};
      vt[1] = '{0,   0, 19, 32'h15141413};
      vt[2] = '{2, 255, 23, 32'h15171413};
      vt[3] = '{3, 148, 23, 32'h17171413};
      vt[4] = '{0,  63, 20, 32'h17171414};
      vt[5] = '{1,  19, 19, 32'h17171314};
      vt[6] = '{1,  21, 20, 32'h17171414};

      // Reset state and INIT duration
      do_reset();
      chk("rst_ready", sample_ready, 0);
      chk("rst_avg_valid", avg_valid, 0);
      chk("rst_avg_road", avg_road, 0);
      chk("rst_avg_out", avg_out, 20);
      chk("rst_avg_all", avg_all, 32'h14141414);
      wait_ready(n, pulses);
      chk("init_cycles", n, 256);
      chk("init_pulses", pulses, 0);
      chk("init_avg_all", avg_all, 32'h14141414);

      // Single-sample updates
      for (int i = 0; i < 7; i++) begin
         send(vt[i].road, vt[i].data, lat);
         chk($sformatf("v%0d_latency", i), lat, 3);
         chk($sformatf("v%0d_avg_road", i), avg_road, vt[i].road);
         chk($sformatf("v%0d_avg_out", i), avg_out, vt[i].exp_avg);
         chk($sformatf("v%0d_avg_all", i), avg_all, vt[i].exp_all);
         step();
         chk($sformatf("v%0d_pulse_width", i), avg_valid, 0);
         chk($sformatf("v%0d_avg_out_hold", i), avg_out, vt[i].exp_avg);
      end

      // Fill road1 with 255, then wrap one slot with 0
      do_reset();
      wait_ready(n, pulses);
      for (int k = 0; k < 64; k++) send(1, 255, lat);
      chk("full_avg_out", avg_out, 255);
      chk("full_avg_all", avg_all, 32'h1414FF14);
      send(1, 0, lat);
      chk("wrap_latency", lat, 3);
      chk("wrap_avg_out", avg_out, 251);
      chk("wrap_avg_all", avg_all, 32'h1414FB14);

      // Reset while a road2 sample is in READ
      sample_valid = 1'b1;
      sample_road  = 2'd2;
      sample_data  = 8'd77;
      step();
      sample_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst_avg_valid", avg_valid, 0);
      chk("midrst_ready", sample_ready, 0);
      chk("midrst_avg_all", avg_all, 32'h14141414);
      wait_ready(n, pulses);
      chk("midrst_init_cycles", n, 256);
      chk("midrst_pulses", pulses, 0);
      send(2, 84, lat);
      chk("midrst_next_avg_out", avg_out, 21);
      chk("midrst_next_avg_all", avg_all, 32'h14151414);

      // Three-road instance: road index 3 is dropped
      reset3 = 1'b0;
      n = 0;
      while (!ready3 && n < 2000) begin
         step();
         n++;
      end
      chk("r3_init_cycles", n, 192);
      valid3 = 1'b1;
      road3  = 2'd3;
      data3  = 8'd99;
      step();
      valid3 = 1'b0;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (avg_valid3) pulses++;
      end
      chk("r3_drop_pulses", pulses, 0);
      chk("r3_drop_avg_all", avg_all3, 24'h141414);
      chk("r3_drop_ready", ready3, 1);
      valid3 = 1'b1;
      road3  = 2'd0;
      data3  = 8'd84;
      step();
      valid3 = 1'b0;
      lat = 1;
      while (!avg_valid3 && lat < 8) begin
         step();
         lat++;
      end
      chk("r3_next_latency", lat, 3);
      chk("r3_next_avg_road", avg_road3, 0);
      chk("r3_next_avg_out", avg_out3, 21);
      chk("r3_next_avg_all", avg_all3, 24'h141415);

`ifdef SENSOR_CONGEST_EN
      // Congestion rises at sample 61 of 210 and falls at the 4th zero
      do_reset();
      chk("cg_rst", congest, 0);
      wait_ready(n, pulses);
      rise = -1;
      for (int k = 1; k <= 64; k++) begin
         send(0, 210, lat);
         if (rise < 0 && congest[0]) rise = k;
      end
      chk("cg_rise_index", rise, 61);
      chk("cg_full_avg", avg_out, 210);
      chk("cg_others", congest[3:1], 0);
      fall = -1;
      for (int k = 1; k <= 64; k++) begin
         send(0, 0, lat);
         if (fall < 0 && !congest[0]) fall = k;
      end
      chk("cg_fall_index", fall, 4);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
